// File: rtl/udp_tx_sched_if.sv
// Handshake bundle between the UDP transmit sources/mux and the packet scheduler.
// The master side (sources + mux) drives request and beat status; the scheduler returns a one-hot grant.
interface udp_tx_sched_if #(
  parameter int N = 3
);
  logic [N-1:0] req;
  logic         beat_vld;
  logic         beat_rdy;
  logic         beat_last;
  logic [N-1:0] gnt;

  modport master (
    output req,
    output beat_vld,
    output beat_rdy,
    output beat_last,
    input  gnt
  );

  modport slave (
    input  req,
    input  beat_vld,
    input  beat_rdy,
    input  beat_last,
    output gnt
  );
endinterface

// File: rtl/udp_tx_sched.sv
// Packet-granular weighted round-robin scheduler for the shared IP/UDP output mux.
// Ownership changes only on a last-beat handshake; a stall watchdog flags a silent owner without aborting it.
module udp_tx_sched #(
  parameter int N  = 3,
  parameter int WW = 4,
  parameter int TW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sched_en_i,
  input  logic [N*WW-1:0] weight_i,
  input  logic [TW-1:0]   stall_lim_i,
  udp_tx_sched_if.slave   bus,
  output logic            busy_o,
  output logic            timeout_o
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    if (p == PW'(N - 1)) return '0;
    return p + PW'(1);
  endfunction

  // Rotating priority search starting at p; MSB of the result is the "found" flag.
  function automatic logic [PW:0] sel_fn(input logic [PW-1:0] p, input logic [N-1:0] r);
    logic [PW-1:0] idx;
    logic [PW-1:0] res;
    logic          found;
    idx   = p;
    res   = p;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && r[idx]) begin
        found = 1'b1;
        res   = idx;
      end
      idx = wrap_inc(idx);
    end
    return {found, res};
  endfunction

  logic [0:0]             state_reg, state_next;
  logic [PW-1:0]          ptr_reg, ptr_next;
  logic [N-1:0]           gnt_reg, gnt_next;
  logic [N-1:0][WW-1:0]   used_reg, used_next;
  logic [TW-1:0]          stall_cnt_reg, stall_cnt_next;
  logic                   timeout_reg, timeout_next;

  logic [WW-1:0]          cur_wt;
  logic [WW-1:0]          eff_wt;
  logic [WW:0]            used_inc;
  logic                   pkt_end;
  logic                   turn_done;
  logic                   grant_go;
  logic                   clr_en;
  logic [PW-1:0]          srch_ptr;
  logic [PW-1:0]          pick_idx;
  logic                   pick_found;

  // While a packet is in flight ptr_reg is the owning channel, so its weight/usage are read directly.
  assign cur_wt    = weight_i[ptr_reg*WW +: WW];
  assign eff_wt    = (cur_wt == '0) ? WW'(1) : cur_wt;
  assign used_inc  = {1'b0, used_reg[ptr_reg]} + (WW+1)'(1);
  assign turn_done = (used_inc >= {1'b0, eff_wt});

  assign pkt_end   = (state_reg == ST_XFER) & bus.beat_vld & bus.beat_rdy & bus.beat_last;
  assign srch_ptr  = (pkt_end && turn_done) ? wrap_inc(ptr_reg) : ptr_reg;

  assign {pick_found, pick_idx} = sel_fn(srch_ptr, bus.req);

  assign grant_go  = sched_en_i & pick_found & ((state_reg == ST_IDLE) | pkt_end);
  // Moving away from the searched channel forfeits whatever remains of its turn.
  assign clr_en    = grant_go & (pick_idx != srch_ptr);

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    gnt_next   = gnt_reg;
    if (grant_go) begin
      state_next = ST_XFER;
      ptr_next   = pick_idx;
      gnt_next   = N'(1) << pick_idx;
    end else if (pkt_end) begin
      state_next = ST_IDLE;
      ptr_next   = srch_ptr;
      gnt_next   = '0;
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_used
      assign used_next[gi] =
        (clr_en && (srch_ptr == PW'(gi)))  ? '0 :
        (pkt_end && (ptr_reg == PW'(gi)))  ? (turn_done ? '0 : used_inc[WW-1:0]) :
                                             used_reg[gi];
    end
  endgenerate

  // Backpressure (vld high, rdy low) is progress from the source's point of view, so only vld matters.
  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    timeout_next   = 1'b0;
    if ((state_reg != ST_XFER) || bus.beat_vld) begin
      stall_cnt_next = '0;
    end else if ((stall_lim_i != '0) && (stall_cnt_reg < stall_lim_i)) begin
      stall_cnt_next = stall_cnt_reg + TW'(1);
      timeout_next   = ((stall_cnt_reg + TW'(1)) == stall_lim_i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= '0;
      gnt_reg       <= '0;
      used_reg      <= '0;
      stall_cnt_reg <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      gnt_reg       <= gnt_next;
      used_reg      <= used_next;
      stall_cnt_reg <= stall_cnt_next;
      timeout_reg   <= timeout_next;
    end
  end

  assign bus.gnt   = gnt_reg;
  assign busy_o    = (state_reg == ST_XFER);
  assign timeout_o = timeout_reg;
endmodule

// File: tb/tb_udp_tx_sched.sv
// Bench for udp_tx_sched: directed scenarios with fixed expectations, then a randomized run
// compared cycle by cycle against a behavioural model of the packet scheduling rules.
module tb_udp_tx_sched;
  localparam int N  = 3;
  localparam int WW = 4;
  localparam int TW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            sched_en;
  logic [N*WW-1:0] weight;
  logic [TW-1:0]   stall_lim;
  logic            busy;
  logic            timeout;

  udp_tx_sched_if #(.N(N)) bus ();

  udp_tx_sched #(.N(N), .WW(WW), .TW(TW)) dut (
    .clk         (clk),
    .reset       (reset),
    .sched_en_i  (sched_en),
    .weight_i    (weight),
    .stall_lim_i (stall_lim),
    .bus         (bus),
    .busy_o      (busy),
    .timeout_o   (timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Behavioural model: owner (-1 = none), search pointer, per-channel packets used this turn, stall run.
  bit m_on = 1'b0;
  int m_own;
  int m_ptr;
  int m_stall;
  int m_used [N];
  bit m_to;

  int wseq [10] = '{0, 1, 1, 1, 2, 2, 0, 1, 1, 1};

  function automatic int tb_sel(input int p, input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (p + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int c);
    logic [N-1:0] v;
    v = '0;
    if (c >= 0) v[c] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_own = -1; m_ptr = 0; m_stall = 0; m_to = 1'b0;
    for (int i = 0; i < N; i++) m_used[i] = 0;
  endtask

  task automatic model_step();
    int c, w, srch, nx;
    m_to = 1'b0;
    if (m_own < 0) begin
      m_stall = 0;
      if (sched_en && (bus.req != '0)) begin
        nx = tb_sel(m_ptr, bus.req);
        if (nx != m_ptr) m_used[m_ptr] = 0;
        m_ptr = nx;
        m_own = nx;
      end
    end else if (bus.beat_vld && bus.beat_rdy && bus.beat_last) begin
      c = m_own;
      w = int'(weight[c*WW +: WW]);
      if (w == 0) w = 1;
      srch = c;
      if (m_used[c] + 1 >= w) begin
        m_used[c] = 0;
        srch = (c + 1) % N;
      end else begin
        m_used[c]++;
      end
      if (sched_en && (bus.req != '0)) begin
        nx = tb_sel(srch, bus.req);
        if (nx != srch) m_used[srch] = 0;
        m_ptr = nx;
        m_own = nx;
      end else begin
        m_ptr = srch;
        m_own = -1;
      end
      m_stall = 0;
      $display("pkt ch%0d done weight=%0d next_owner=%0d", c, w, m_own);
    end else if (bus.beat_vld) begin
      m_stall = 0;
    end else if ((stall_lim != '0) && (m_stall < int'(stall_lim))) begin
      m_stall++;
      if (m_stall == int'(stall_lim)) m_to = 1'b1;
    end
  endtask

  task automatic set_beat(input bit v, input bit r, input bit l);
    bus.beat_vld  = v;
    bus.beat_rdy  = r;
    bus.beat_last = l;
  endtask

  // Inputs change at the falling edge; outputs are sampled at the next falling edge.
  task automatic tick();
    @(posedge clk);
    if (m_on) model_step();
    @(negedge clk);
    if (m_on) begin
      check_val("rnd_gnt",     32'(bus.gnt), 32'(oh(m_own)));
      check_val("rnd_busy",    32'(busy),    32'(m_own >= 0));
      check_val("rnd_timeout", 32'(timeout), 32'(m_to));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req = '0;
    set_beat(0, 0, 0);
    @(negedge clk);
    check_val("rst_gnt",  32'(bus.gnt), 32'(0));
    check_val("rst_busy", 32'(busy),    32'(0));
    check_val("rst_to",   32'(timeout), 32'(0));
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int pulses;
    reset     = 1'b1;
    sched_en  = 1'b1;
    weight    = {4'd1, 4'd1, 4'd1};
    stall_lim = '0;
    bus.req   = '0;
    set_beat(0, 0, 0);
    model_reset();
    @(negedge clk);
    do_reset();

    // Single request, 3-beat packet, release when request drops
    tick();
    check_val("idle_noreq", 32'(bus.gnt), 32'(0));
    bus.req = 3'b010;
    tick();
    check_val("a_grant", 32'(bus.gnt), 32'(3'b010));
    check_val("a_busy",  32'(busy),    32'(1));
    set_beat(1, 1, 0);
    tick();
    check_val("a_hold1", 32'(bus.gnt), 32'(3'b010));
    tick();
    check_val("a_hold2", 32'(bus.gnt), 32'(3'b010));
    set_beat(1, 1, 1);
    bus.req = '0;
    tick();
    check_val("a_release", 32'(bus.gnt), 32'(0));
    check_val("a_idle",    32'(busy),    32'(0));

    // Equal weights, 2-beat packets, no gap between owners
    do_reset();
    bus.req = 3'b111;
    tick();
    for (int p = 0; p < 6; p++) begin
      check_val("rr_order", 32'(bus.gnt), 32'(oh(p % 3)));
      set_beat(1, 1, 0);
      tick();
      check_val("rr_mid", 32'(bus.gnt), 32'(oh(p % 3)));
      set_beat(1, 1, 1);
      if (p == 5) bus.req = '0;
      tick();
    end
    set_beat(0, 0, 0);
    check_val("rr_end", 32'(bus.gnt), 32'(0));

    // Weighted turns with single-beat packets
    do_reset();
    weight  = {4'd2, 4'd3, 4'd1};
    bus.req = 3'b111;
    tick();
    for (int i = 0; i < 10; i++) begin
      check_val("wrr_seq", 32'(bus.gnt), 32'(oh(wseq[i])));
      set_beat(1, 1, 1);
      if (i == 9) bus.req = '0;
      tick();
    end
    set_beat(0, 0, 0);
    check_val("wrr_end", 32'(bus.gnt), 32'(0));

    // Skip a dropped requester; its next turn starts fresh
    do_reset();
    weight  = {4'd4, 4'd4, 4'd4};
    bus.req = 3'b001;
    tick();
    for (int i = 0; i < 2; i++) begin
      check_val("skip_ch0", 32'(bus.gnt), 32'(3'b001));
      set_beat(1, 1, 1);
      if (i == 1) bus.req = 3'b100;
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      check_val("skip_ch2", 32'(bus.gnt), 32'(3'b100));
      set_beat(1, 1, 1);
      if (i == 3) bus.req = 3'b101;
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      check_val("fresh_ch0", 32'(bus.gnt), 32'(3'b001));
      set_beat(1, 1, 1);
      tick();
    end
    check_val("fresh_next", 32'(bus.gnt), 32'(3'b100));
    bus.req = '0;
    tick();
    set_beat(0, 0, 0);
    check_val("skip_end", 32'(bus.gnt), 32'(0));

    // Watchdog pulse on the 5th silent cycle; backpressure never counts
    do_reset();
    weight    = {4'd1, 4'd1, 4'd1};
    stall_lim = 16'd5;
    bus.req   = 3'b010;
    tick();
    check_val("wd_grant", 32'(bus.gnt), 32'(3'b010));
    set_beat(1, 1, 0);
    tick();
    set_beat(0, 0, 0);
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_val("wd_pulse", 32'(timeout), 32'(k == 5));
      check_val("wd_hold",  32'(bus.gnt), 32'(3'b010));
      pulses += int'(timeout);
    end
    set_beat(1, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      check_val("bp_nopulse", 32'(timeout), 32'(0));
      check_val("bp_hold",    32'(bus.gnt), 32'(3'b010));
      pulses += int'(timeout);
    end
    check_val("wd_count", 32'(pulses), 32'(1));
    set_beat(1, 1, 1);
    bus.req = '0;
    tick();
    set_beat(0, 0, 0);
    check_val("wd_end", 32'(bus.gnt), 32'(0));

    // Enable dropped mid-packet, then reset mid-packet
    do_reset();
    stall_lim = '0;
    bus.req   = 3'b001;
    tick();
    check_val("en_grant", 32'(bus.gnt), 32'(3'b001));
    set_beat(1, 1, 0);
    sched_en = 1'b0;
    tick();
    check_val("en_hold", 32'(bus.gnt), 32'(3'b001));
    check_val("en_busy", 32'(busy),    32'(1));
    set_beat(1, 1, 1);
    bus.req = 3'b111;
    tick();
    check_val("en_stop",  32'(bus.gnt), 32'(0));
    check_val("en_idle",  32'(busy),    32'(0));
    set_beat(0, 0, 0);
    tick();
    check_val("en_stop2", 32'(bus.gnt), 32'(0));
    sched_en = 1'b1;
    tick();
    check_val("en_resume", 32'(bus.gnt), 32'(3'b010));
    set_beat(1, 1, 0);
    tick();
    reset = 1'b1;
    #1;
    check_val("rst_async_gnt",  32'(bus.gnt), 32'(0));
    check_val("rst_async_busy", 32'(busy),    32'(0));
    @(negedge clk);
    reset = 1'b0;
    set_beat(0, 0, 0);
    tick();
    check_val("rst_first", 32'(bus.gnt), 32'(3'b001));

    // Randomized run against the model
    do_reset();
    stall_lim = 16'd3;
    m_on = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 49) == 0)
        for (int i = 0; i < N; i++) weight[i*WW +: WW] = WW'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) stall_lim = TW'($urandom_range(0, 4));
      sched_en = ($urandom_range(0, 9) != 0);
      bus.req  = N'($urandom_range(0, 7));
      if (m_own >= 0)
        set_beat($urandom_range(0, 9) < 6, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      else
        set_beat(0, 0, 0);
      tick();
    end
    m_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/udp_tx_sched.md
# udp_tx_sched

Packet-granular weighted round-robin scheduler for the UDP transmit path. It decides which of N header+payload sources (search-device, AXI2UDP, user stream) owns the shared IP/UDP output mux, one whole packet at a time. Grant changes are permitted only on AXI-Stream packet boundaries. It sits beside the mux: it reads per-source valid and the handshake at the mux output, and drives a one-hot select into the mux.

## Interface
Parameters:
- N, 3: number of requesters.
- WW, 4: width of each per-channel weight (packets per turn).
- TW, 16: width of stall watchdog counter/limit.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- sched_en_i  in  1  1 = new grants allowed. 0 = packet in flight completes, then no new grants.
- weight_i  in  N*WW  per-channel weight; channel i at [i*WW +: WW]; value 0 is treated as 1.
- stall_lim_i  in  TW  watchdog limit in cycles; 0 disables the watchdog.
- req_i  in  N  per-source tvld (source has a beat/packet pending).
- beat_vld_i  in  1  tvld of the currently granted source, as presented to the mux.
- beat_rdy_i  in  1  trdy returned to the granted source.
- beat_last_i  in  1  tlast of the granted source.
- gnt_o  out  N  registered one-hot grant; all-zero = no owner.
- busy_o  out  1  1 while a packet is granted (state XFER).
- timeout_o  out  1  one-cycle pulse on watchdog expiry.

## Operation
- States: IDLE (gnt_o=0) and XFER (gnt_o one-hot, busy_o=1).
- Registers:
  - ptr: last granted channel, 0..N-1.
  - used[i]: packets sent in the current turn, WW bits.
  - stall_cnt: TW bits.
- Selection function sel(p, r): first set bit of r searching p, p+1, …, N-1, 0, …, p-1. Result is "none" if r is all-zero.
- IDLE -> XFER when sched_en_i=1 and req_i≠0. The grant goes to c = sel(ptr, req_i).
- Issuing a grant to c:
  - If c≠ptr: set used[ptr]<=0 and ptr<=c.
  - Otherwise ptr is unchanged.
- Packet end: a cycle in XFER with beat_vld_i & beat_rdy_i & beat_last_i.
- On packet end for channel c, let w = max(weight_i[c],1), sampled at this edge:
  - If used[c]+1 >= w: the turn is exhausted. used[c]<=0 and the search pointer becomes (c+1) mod N.
  - Otherwise used[c]<=used[c]+1 and the search pointer stays at c.
- Back-to-back grants: on the packet-end edge, the next grant is computed as sel(search pointer, req_i), using the updated pointer and the current req_i. The same edge applies it.
  - If sched_en_i=0 or no requester: go to IDLE.
  - Otherwise stay in XFER with the new one-hot. The new grant may be the same channel.
- sched_en_i only gates new grants. Deasserting it mid-packet never drops gnt_o before packet end.
- weight_i may change at any time. The new value takes effect at the next packet-end compare. A used[c] already ≥ the new weight ends the turn at that packet.
- Watchdog (XFER only):
  - stall_cnt clears on any cycle with beat_vld_i=1, and on every grant change.
  - It increments on each cycle with beat_vld_i=0 and saturates at stall_lim_i.
  - timeout_o pulses exactly once, on the edge where stall_cnt reaches stall_lim_i (stall_lim_i≠0).
  - The grant is held; the block never aborts a packet.
  - A further pulse requires a beat_vld_i=1 cycle first.
- Downstream backpressure (beat_vld_i=1, beat_rdy_i=0) never counts as a stall.

## Timing
- Reset values: gnt_o=0, busy_o=0, timeout_o=0, state IDLE, ptr=0, all used=0, stall_cnt=0.
- Reset asserted mid-packet releases the grant immediately (asynchronously).
- Grant latency: req_i sampled high in IDLE at edge t gives gnt_o valid after edge t, i.e. visible in cycle t+1.
- Packet switch: last-beat handshake in cycle t gives the new gnt_o in cycle t+1. There is zero idle cycle between packets.
- A single-beat packet (tvld and tlast together) is legal. Grant then lasts one cycle if the beat handshakes immediately.
- gnt_o, busy_o and timeout_o are registered outputs only. There is no combinational path from inputs to outputs.

## Test plan
- Reset and single request: reset, weights all 1, req_i=3'b010 at cycle 5.
  - Required: gnt_o=3'b010 from cycle 6.
  - 3-beat packet (last handshaked cycle 8) with req_i dropping: gnt_o=0 and busy_o=0 in cycle 9.
- Equal-weight round robin: all req_i held high, weights 1, 2-beat packets, continuous trdy.
  - Required: grant order 0,1,2,0,1,2.
  - Each switch occurs the cycle after the last beat, with no gap.
- Weighted turns: weight_i={2,3,1} for channels {2,1,0}, all requesting, 1-beat packets.
  - Required: packet sequence 0,1,1,1,2,2,0,1,1,1.
- Skip and pointer reset: weights 4, ch0 sends 2 packets then drops req while ch2 requests.
  - Required: grant moves to ch2.
  - When ch0 re-requests after ch2's turn, it receives a full fresh 4-packet turn.
- Watchdog and backpressure: stall_lim_i=5, granted source drops tvld for 8 cycles mid-packet.
  - Required: exactly one timeout_o pulse, on the 5th idle cycle; grant held.
  - 20 cycles of tvld=1 with trdy=0: no pulse.
- Enable and reset mid-packet: sched_en_i=0 during a packet.
  - Required: the packet completes, then gnt_o=0 despite pending req_i.
  - reset asserted mid-packet: gnt_o=0 in the same cycle; first grant after release goes to ch0 if requesting.
